// File: rtl/tensor_core_pkg.sv
// =============================================================================
// Module      : tensor_core_pkg
// Description : Shared types and constants for the tensor core result path.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package tensor_core_pkg;

    localparam int MATRIX_DIM          = 4;
    localparam int ELEMENTS_PER_MATRIX = MATRIX_DIM * MATRIX_DIM;

    // Indexed as [row][col]; each element is one byte.
    typedef logic [MATRIX_DIM-1:0][MATRIX_DIM-1:0][7:0] byte_matrix_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } serializer_state_t;

endpackage

`default_nettype wire

// File: rtl/tensor_core_result_serializer.sv
// =============================================================================
// Module      : tensor_core_result_serializer
// Description : Snapshots all result matrices and streams them byte by byte.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tensor_core_result_serializer
    import tensor_core_pkg::*;
#(
    parameter  int NUMBER_OF_MATRICES = 2,
    localparam int INDEX_WIDTH        = $clog2(ELEMENTS_PER_MATRIX * NUMBER_OF_MATRICES)
) (
    input  logic                                   clock_in,
    input  logic                                   reset_n_in,
    input  logic                                   capture_enable_in,
    input  byte_matrix_t [NUMBER_OF_MATRICES-1:0]  matrix_data_in,
    output logic [7:0]                             data_out,
    output logic [INDEX_WIDTH-1:0]                 data_index_out,
    output logic                                   data_valid_out,
    input  logic                                   data_ready_in,
    output logic                                   last_out,
    output logic                                   busy_out,
    output logic                                   done_out
);

    localparam logic [INDEX_WIDTH-1:0] c_LAST_INDEX =
        INDEX_WIDTH'(ELEMENTS_PER_MATRIX * NUMBER_OF_MATRICES - 1);

    serializer_state_t                      r_state;
    byte_matrix_t [NUMBER_OF_MATRICES-1:0]  r_snapshot;
    logic [INDEX_WIDTH-1:0]                 r_index;
    logic [7:0]                             r_data;
    logic                                   r_valid;
    logic                                   r_last;
    logic                                   r_busy;
    logic                                   r_done;
    logic [INDEX_WIDTH-1:0]                 w_next_index;

    // Index bits split as {matrix, row[1:0], col[1:0]}.
    function automatic logic [7:0] f_element(
        input byte_matrix_t [NUMBER_OF_MATRICES-1:0] mats,
        input logic [INDEX_WIDTH-1:0]                idx
    );
        return mats[idx[INDEX_WIDTH-1:4]][idx[3:2]][idx[1:0]];
    endfunction

    assign w_next_index = r_index + 1'b1;

    always_ff @(posedge clock_in) begin
        if (!reset_n_in) begin
            r_state    <= ST_IDLE;
            r_snapshot <= '0;
            r_index    <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (capture_enable_in) begin
                        r_snapshot <= matrix_data_in;
                        r_index    <= '0;
                        r_data     <= f_element(matrix_data_in, {INDEX_WIDTH{1'b0}});
                        r_valid    <= 1'b1;
                        r_last     <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    // Output registers only move on an accepted transfer.
                    if (data_ready_in) begin
                        if (r_index == c_LAST_INDEX) begin
                            r_state <= ST_DONE;
                            r_valid <= 1'b0;
                            r_last  <= 1'b0;
                            r_data  <= '0;
                            r_index <= '0;
                            r_done  <= 1'b1;
                        end else begin
                            r_index <= w_next_index;
                            r_data  <= f_element(r_snapshot, w_next_index);
                            r_last  <= (w_next_index == c_LAST_INDEX);
                        end
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_out       = r_data;
    assign data_index_out = r_index;
    assign data_valid_out = r_valid;
    assign last_out       = r_last;
    assign busy_out       = r_busy;
    assign done_out       = r_done;

endmodule

`default_nettype wire
